// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in, serial-out shift register with a load handshake.
//            Accepts a WIDTH-bit word and emits it one bit per clock, qualified
//            by serial_valid. A word may be accepted in the last-bit cycle of
//            the previous word, so back-to-back words stream without a gap.
//            The serial stream can drive a SIPO receiver bit-for-bit.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous reset, active-low
//            load_valid   - data_in holds a word to send
//            data_in      - parallel word [WIDTH-1:0]
//            load_ready   - word can be accepted this cycle (combinational)
//            serial_out   - serial data bit (registered)
//            serial_valid - serial_out carries a valid bit (registered)
//            busy         - a word is being shifted out (== serial_valid)
//            done         - one-cycle pulse coincident with the last bit
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int                 C_CNT_W = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic               r_sout;
  logic               w_sout_nxt;
  logic               r_sval;
  logic               w_sval_nxt;

  logic               w_last;
  logic               w_accept;
  logic               w_first_bit;
  logic               w_next_bit;
  logic [WIDTH-1:0]   w_load_shift;
  logic [WIDTH-1:0]   w_shift_adv;

  // The first bit goes straight to serial_out on the accept edge, so the
  // shift register holds only the bits still to be sent, pre-aligned so the
  // next bit always sits at the outgoing end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit  = data_in[WIDTH-1];
      assign w_load_shift = {data_in[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shift[WIDTH-1];
      assign w_shift_adv  = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = data_in[0];
      assign w_load_shift = {1'b0, data_in[WIDTH-1:1]};
      assign w_next_bit   = r_shift[0];
      assign w_shift_adv  = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // Counter holds the index of the bit currently on serial_out.
  assign w_last     = (r_cnt == C_LAST);
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  assign serial_out   = r_sout;
  assign serial_valid = r_sval;
  assign busy         = r_sval;
  assign done         = r_sval && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_sval  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sout  <= w_sout_nxt;
      r_sval  <= w_sval_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_sout_nxt  = r_sout;
    w_sval_nxt  = r_sval;

    if (w_accept) begin
      // Covers both a fresh start from IDLE and a gapless reload in the
      // last-bit cycle; the counter restarts at bit 0 either way.
      w_state_nxt = SHIFT;
      w_shift_nxt = w_load_shift;
      w_cnt_nxt   = '0;
      w_sout_nxt  = w_first_bit;
      w_sval_nxt  = 1'b1;
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            w_sout_nxt  = 1'b0;
            w_sval_nxt  = 1'b0;
          end else begin
            w_shift_nxt = w_shift_adv;
            w_cnt_nxt   = r_cnt + C_CNT_W'(1);
            w_sout_nxt  = w_next_bit;
            w_sval_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench for piso_serializer. Two instances (MSB-first
//            and LSB-first) share one stimulus stream. A queue-based reference
//            model turns every accepted word into its expected bit stream, and
//            a behavioural SIPO rebuilds each word from the serial output.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic m_ready, m_sout, m_sval, m_busy, m_done;
  logic l_ready, l_sout, l_sval, l_busy, l_done;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .data_in(data_in),
    .load_ready(m_ready), .serial_out(m_sout), .serial_valid(m_sval),
    .busy(m_busy), .done(m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .data_in(data_in),
    .load_ready(l_ready), .serial_out(l_sout), .serial_valid(l_sval),
    .busy(l_busy), .done(l_done)
  );

  // Reference model: each accepted word becomes W queued bits; one bit is
  // presented per clock. The bench is ready when nothing is shown or the
  // shown bit is the last of its word.
  typedef struct {
    logic b;
    logic last;
  } ebit_t;

  ebit_t        qm[$];
  ebit_t        ql[$];
  ebit_t        cm;
  ebit_t        cl;
  logic         cmv = 1'b0;
  logic         clv = 1'b0;
  logic [W-1:0] sent_m[$];
  logic [W-1:0] sent_l[$];
  logic [W-1:0] rx_m = '0;
  logic [W-1:0] rx_l = '0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qm.delete();
    ql.delete();
    sent_m.delete();
    sent_l.delete();
    cmv  = 1'b0;
    clv  = 1'b0;
    rx_m = '0;
    rx_l = '0;
  endtask

  task automatic model_edge(input logic lv, input logic [W-1:0] din);
    logic acc;
    if (!rst_n) return;
    acc = lv && (!cmv || cm.last);
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        qm.push_back('{din[W-1-i], (i == W-1)});
        ql.push_back('{din[i], (i == W-1)});
      end
      sent_m.push_back(din);
      sent_l.push_back(din);
    end
    if (qm.size() > 0) begin cm = qm.pop_front(); cmv = 1'b1; end
    else cmv = 1'b0;
    if (ql.size() > 0) begin cl = ql.pop_front(); clv = 1'b1; end
    else clv = 1'b0;
  endtask

  task automatic check_outputs();
    logic [W-1:0] w;
    chk("m.load_ready",   m_ready, (!rst_n || !cmv || cm.last));
    chk("m.serial_valid", m_sval,  cmv);
    chk("m.serial_out",   m_sout,  cmv ? cm.b : 1'b0);
    chk("m.done",         m_done,  cmv && cm.last);
    chk("m.busy",         m_busy,  cmv);
    chk("l.load_ready",   l_ready, (!rst_n || !clv || cl.last));
    chk("l.serial_valid", l_sval,  clv);
    chk("l.serial_out",   l_sout,  clv ? cl.b : 1'b0);
    chk("l.done",         l_done,  clv && cl.last);
    chk("l.busy",         l_busy,  clv);
    // Behavioural SIPO receivers fed straight from the serial outputs.
    if (rst_n && m_sval === 1'b1) begin
      rx_m = {rx_m[W-2:0], m_sout};
      if (m_done === 1'b1) begin
        w = (sent_m.size() > 0) ? sent_m.pop_front() : ~rx_m;
        chk("m.sipo_word", rx_m, w);
      end
    end
    if (rst_n && l_sval === 1'b1) begin
      rx_l = {l_sout, rx_l[W-1:1]};
      if (l_done === 1'b1) begin
        w = (sent_l.size() > 0) ? sent_l.pop_front() : ~rx_l;
        chk("l.sipo_word", rx_l, w);
      end
    end
  endtask

  // Drive inputs, clock once, then check outputs on the falling edge.
  task automatic step(input logic lv, input logic [W-1:0] din);
    load_valid = lv;
    data_in    = din;
    @(posedge clk);
    model_edge(lv, din);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset held with load_valid toggling: everything idle, ready high.
    check_outputs();
    step(1'b1, 4'b1011);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0110);
    step(1'b0, 4'b0000);
    rst_n = 1'b1;
    check_outputs();

    // Single word followed by an idle cycle.
    step(1'b1, 4'b1011);
    repeat (4) step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // Back-to-back: second word presented in the last-bit cycle.
    step(1'b1, 4'b1011);
    repeat (3) step(1'b0, 4'b0000);
    step(1'b1, 4'b0110);
    repeat (3) step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // Load attempt mid-word must be ignored.
    step(1'b1, 4'b1100);
    step(1'b1, 4'b0011);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // Asynchronous reset during bit 2, then a clean restart.
    step(1'b1, 4'b1010);
    step(1'b0, 4'b1111);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    step(1'b1, 4'b1111);
    rst_n = 1'b1;
    step(1'b1, 4'b0111);
    repeat (3) step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // load_valid held high with random words: gapless stream.
    repeat (40) step(1'b1, W'($urandom));
    // Random handshake traffic.
    repeat (200) step(1'($urandom_range(0, 1)), W'($urandom));
    repeat (6) step(1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
